pi_uart_tx: RTL and testbench

- 8N1 UART transmitter driving a GPIO pin back to the Raspberry Pi. This is the FPGA-to-Pi direction of the Pi GPIO link.
- Bytes arrive from fabric logic over a valid/ready handshake and are buffered in a small FIFO.
- Each byte is serialized LSB-first at a fixed baud derived from the 12 MHz board clock.
- tx_active is intended to drive user_led as a link-activity indicator.

---
 rtl/pi_uart_tx_if.sv | 15 +
 rtl/pi_uart_tx.sv | 163 ++++++++++++++++
 tb/tb_pi_uart_tx.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pi_uart_tx_if.sv
// Byte-offer bus between fabric logic and the Pi UART transmitter.
//
// valid/ready: the master drives data_in and raises data_valid; a byte
// moves on every rising clock edge where data_valid && data_ready are both
// high. While data_valid=1 and data_ready=0 the master holds data_in
// stable and keeps data_valid high. data_ready does not depend
// combinationally on data_valid.
interface pi_uart_tx_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/pi_uart_tx.sv
// 8N1 UART transmitter, FPGA-to-Pi direction of the GPIO link.
// Bytes are queued in a small FIFO and shifted out LSB-first at CLK_HZ/BAUD.
// Stop-to-start runs back-to-back when the FIFO still holds data.
module pi_uart_tx #(
  parameter int CLK_HZ     = 12000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk12,
  input  logic             sys_rst_n,
  pi_uart_tx_if.slave      bus,
  output logic             tx_out,
  output logic             tx_active,
  output logic [1:0]       state_dbg
);

  // Bit period in clock cycles; must be at least 2.
  localparam int DIV = CLK_HZ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  // FIFO_DEPTH must be a power of two so pointers wrap naturally.
  localparam int AW  = $clog2(FIFO_DEPTH);

  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_next;
  logic [CW-1:0] baud_cnt, baud_next;
  logic [2:0]    bit_idx, idx_next;
  logic [7:0]    shift_q, shift_next;
  logic          tx_q, tx_next;
  logic          baud_end;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_next;
  logic          ready_q;
  logic          push, pop;
  logic          fifo_empty;
  logic [7:0]    head;

  assign push       = bus.data_valid && ready_q;
  assign fifo_empty = (count == '0);
  assign head       = mem[rd_ptr];

  assign bus.data_ready = ready_q;
  assign tx_out         = tx_q;
  assign state_dbg      = state;

  // FIFO occupancy after this edge; push and pop together cancel out.
  always_comb begin
    count_next = count;
    case ({push, pop})
      2'b10:   count_next = count + CNT_ONE;
      2'b01:   count_next = count - CNT_ONE;
      default: count_next = count;
    endcase
  end

  // Frame sequencer: decides next line level, shift contents and FIFO pop.
  always_comb begin
    state_next = state;
    baud_next  = baud_cnt + BAUD_ONE;
    idx_next   = bit_idx;
    shift_next = shift_q;
    tx_next    = tx_q;
    pop        = 1'b0;
    baud_end   = (baud_cnt == BAUD_LAST);
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = head;
          tx_next    = 1'b0;
          state_next = START;
        end
      end
      START: begin
        if (baud_end) begin
          baud_next  = '0;
          tx_next    = shift_q[0];
          idx_next   = 3'd0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_next = '0;
          if (bit_idx == 3'd7) begin
            tx_next    = 1'b1;
            state_next = STOP;
          end else begin
            shift_next = {1'b0, shift_q[7:1]};
            tx_next    = shift_q[1];
            idx_next   = bit_idx + 3'd1;
          end
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_next = '0;
          // Chain straight into the next start bit when more data waits.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = head;
            tx_next    = 1'b0;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: begin
        baud_next  = '0;
        tx_next    = 1'b1;
        state_next = IDLE;
      end
    endcase
  end

  // FIFO storage; contents need no reset since count gates every read.
  always_ff @(posedge clk12) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // State, counters, FIFO pointers and registered status outputs.
  always_ff @(posedge clk12 or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= 3'd0;
      shift_q   <= 8'h00;
      tx_q      <= 1'b1;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ready_q   <= 1'b1;
      tx_active <= 1'b0;
    end else begin
      state     <= state_next;
      baud_cnt  <= baud_next;
      bit_idx   <= idx_next;
      shift_q   <= shift_next;
      tx_q      <= tx_next;
      count     <= count_next;
      ready_q   <= (count_next != FULL_CNT);
      tx_active <= (state_next != IDLE) || (count_next != '0);
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: tb/tb_pi_uart_tx.sv
// Directed bench for pi_uart_tx: a default-rate instance (DIV=104, depth 4)
// and a fast instance (DIV=4, depth 2) share one clock. A line monitor per
// instance decodes frames; a scoreboard queue holds accepted bytes.
module tb_pi_uart_tx;

  localparam int DIV_A = 12000000 / 115200;   // 104
  localparam int DIV_B = 12000000 / 3000000;  // 4

  // ---------------- clock / reset ----------------
  logic clk12 = 1'b0;
  logic rst_a = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk12 = ~clk12;

  int cyc = 0;
  always @(posedge clk12) cyc <= cyc + 1;

  int rst_cnt_a = 0;
  always @(negedge rst_a) rst_cnt_a <= rst_cnt_a + 1;

  // ---------------- DUTs ----------------
  pi_uart_tx_if bus_a ();
  pi_uart_tx_if bus_b ();
  logic       tx_a, act_a, tx_b, act_b;
  logic [1:0] st_a, st_b;

  pi_uart_tx #(.CLK_HZ(12000000), .BAUD(115200), .FIFO_DEPTH(4)) dut_a (
    .clk12(clk12), .sys_rst_n(rst_a), .bus(bus_a),
    .tx_out(tx_a), .tx_active(act_a), .state_dbg(st_a)
  );

  pi_uart_tx #(.CLK_HZ(12000000), .BAUD(3000000), .FIFO_DEPTH(2)) dut_b (
    .clk12(clk12), .sys_rst_n(rst_b), .bus(bus_b),
    .tx_out(tx_b), .tx_active(act_b), .state_dbg(st_b)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q_a[$];
  logic [7:0] exp_q_b[$];
  logic [8:0] mon_q_a[$];   // {stop bit, data byte}
  logic [8:0] mon_q_b[$];
  int         start_q_a[$];
  int         start_q_b[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic tx_of(input bit sel);
    return sel ? tx_b : tx_a;
  endfunction

  function automatic logic active_of(input bit sel);
    return sel ? act_b : act_a;
  endfunction

  function automatic int mon_size(input bit sel);
    return sel ? mon_q_b.size() : mon_q_a.size();
  endfunction

  // ---------------- line monitor ----------------
  task automatic mon_run(input bit sel, input int div);
    int         st, rc;
    logic [7:0] b;
    logic       stop_bit;
    forever begin
      @(negedge clk12);
      if (tx_of(sel) == 1'b0 && (sel ? rst_b : rst_a)) begin
        st = cyc;
        rc = sel ? 0 : rst_cnt_a;
        repeat (div / 2) @(negedge clk12);
        for (int i = 0; i < 8; i++) begin
          repeat (div) @(negedge clk12);
          b[i] = tx_of(sel);
        end
        repeat (div) @(negedge clk12);
        stop_bit = tx_of(sel);
        // A frame cut short by reset is not a real frame.
        if (rc == (sel ? 0 : rst_cnt_a)) begin
          if (sel) begin
            mon_q_b.push_back({stop_bit, b});
            start_q_b.push_back(st);
          end else begin
            mon_q_a.push_back({stop_bit, b});
            start_q_a.push_back(st);
          end
        end
      end
    end
  endtask

  initial mon_run(1'b0, DIV_A);
  initial mon_run(1'b1, DIV_B);

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push(input bit sel, input logic [7:0] b, input bit scramble,
                      output int t_acc, output int stalls);
    logic [7:0] cur;
    bit         r, done;
    cur = b; stalls = 0; t_acc = -1; done = 0;
    for (int k = 0; k < 5000 && !done; k++) begin
      if (sel) begin
        bus_b.data_in = cur; bus_b.data_valid = 1'b1; r = bus_b.data_ready;
      end else begin
        bus_a.data_in = cur; bus_a.data_valid = 1'b1; r = bus_a.data_ready;
      end
      @(negedge clk12);
      if (r) begin
        done  = 1;
        t_acc = cyc;
        if (sel) exp_q_b.push_back(cur);
        else     exp_q_a.push_back(cur);
      end else begin
        stalls++;
        if (scramble) cur = 8'($urandom_range(0, 255));
      end
    end
    if (!done) check("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drop_valid(input bit sel);
    if (sel) bus_b.data_valid = 1'b0;
    else     bus_a.data_valid = 1'b0;
  endtask

  // Pushes one byte from idle and compares every line/active sample of the frame.
  task automatic wave_check(input bit sel, input logic [7:0] b, input int div, input string tag);
    int         t, s, tx_err, act_err;
    logic [9:0] fr;
    logic       exp_tx;
    fr = {1'b1, b, 1'b0};
    push(sel, b, 1'b0, t, s);
    drop_valid(sel);
    check({tag, "_pre_line"}, 32'(tx_of(sel)), 32'd1);
    check({tag, "_pre_active"}, 32'(active_of(sel)), 32'd1);
    tx_err = 0; act_err = 0;
    for (int c = 0; c < 10 * div + 6; c++) begin
      @(negedge clk12);
      exp_tx = (c < 10 * div) ? fr[c / div] : 1'b1;
      if (c == 0) check({tag, "_fall"}, 32'(tx_of(sel)), 32'd0);
      if (tx_of(sel) !== exp_tx) tx_err++;
      if (active_of(sel) !== (c < 10 * div)) act_err++;
    end
    check({tag, "_line_errs"}, 32'(tx_err), 32'd0);
    check({tag, "_active_errs"}, 32'(act_err), 32'd0);
  endtask

  // Waits for n decoded frames and compares them to the scoreboard.
  task automatic expect_frames(input bit sel, input int n, input int div, input bit gap,
                               input string tag, output int first_start);
    int         waited, st, prev;
    logic [8:0] got;
    logic [7:0] e;
    waited = 0; first_start = -1; prev = 0;
    while (mon_size(sel) < n && waited < n * 11 * div + 400) begin
      @(negedge clk12);
      waited++;
    end
    if (mon_size(sel) < n) check({tag, "_timeout"}, 32'(mon_size(sel)), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (mon_size(sel) == 0) break;
      if (sel) begin
        got = mon_q_b.pop_front(); st = start_q_b.pop_front();
        e = (exp_q_b.size() != 0) ? exp_q_b.pop_front() : 8'h00;
      end else begin
        got = mon_q_a.pop_front(); st = start_q_a.pop_front();
        e = (exp_q_a.size() != 0) ? exp_q_a.pop_front() : 8'h00;
      end
      check(tag, 32'(got), 32'({1'b1, e}));
      if (i == 0) first_start = st;
      else if (gap) check({tag, "_gap"}, 32'(st - prev), 32'(10 * div));
      prev = st;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int         t[6];
    int         s, fs, low_cnt, act_cnt, target;
    logic       smp[10];
    bit         exp_a5[8];
    exp_a5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    bus_a.data_in = 8'h00; bus_a.data_valid = 1'b0;
    bus_b.data_in = 8'h00; bus_b.data_valid = 1'b0;

    // Reset state, checked while reset is held and after release.
    repeat (3) @(negedge clk12);
    check("rst_tx_a", 32'(tx_a), 32'd1);
    check("rst_ready_a", 32'(bus_a.data_ready), 32'd1);
    check("rst_active_a", 32'(act_a), 32'd0);
    check("rst_state_a", 32'(st_a), 32'd0);
    check("rst_tx_b", 32'(tx_b), 32'd1);
    check("rst_ready_b", 32'(bus_b.data_ready), 32'd1);
    check("rst_active_b", 32'(act_b), 32'd0);
    rst_a = 1'b1; rst_b = 1'b1;
    repeat (3) @(negedge clk12);
    check("post_rst_tx_a", 32'(tx_a), 32'd1);
    check("post_rst_active_a", 32'(act_a), 32'd0);

    // 1: single 0x55 from idle, full waveform and activity window.
    wave_check(1'b0, 8'h55, DIV_A, "t1");
    expect_frames(1'b0, 1, DIV_A, 1'b0, "t1_byte", fs);
    repeat (100) @(negedge clk12);

    // 2: 0xA5 sampled at the centre of each bit.
    push(1'b0, 8'hA5, 1'b0, t[0], s);
    drop_valid(1'b0);
    for (int c = 0; c < 10 * DIV_A; c++) begin
      @(negedge clk12);
      if (c % DIV_A == DIV_A / 2) smp[c / DIV_A] = tx_a;
    end
    check("t2_start", 32'(smp[0]), 32'd0);
    for (int i = 0; i < 8; i++) check($sformatf("t2_bit%0d", i), 32'(smp[i + 1]), 32'(exp_a5[i]));
    check("t2_stop", 32'(smp[9]), 32'd1);
    expect_frames(1'b0, 1, DIV_A, 1'b0, "t2_byte", fs);
    repeat (100) @(negedge clk12);

    // 3: burst 0x01..0x06 with valid held high.
    for (int i = 0; i < 6; i++) push(1'b0, 8'(i + 1), 1'b0, t[i], s);
    drop_valid(1'b0);
    for (int i = 1; i < 5; i++) check($sformatf("t3_acc%0d", i), 32'(t[i] - t[0]), 32'(i));
    check("t3_acc6", 32'(t[5] - t[0]), 32'd1042);
    check("t3_ready_low_cycles", 32'(s), 32'd1037);
    expect_frames(1'b0, 6, DIV_A, 1'b1, "t3_frames", fs);
    check("t3_first_start", 32'(fs - t[0]), 32'd1);
    repeat (200) @(negedge clk12);

    // 4: data_in churns while stalled; only the byte present at accept counts.
    for (int i = 0; i < 5; i++) push(1'b0, 8'(8'h10 + i), 1'b0, t[0], s);
    push(1'b0, 8'h20, 1'b1, t[0], s);
    check("t4_stalled", 32'(s > 0), 32'd1);
    push(1'b0, 8'h21, 1'b0, t[0], s);
    drop_valid(1'b0);
    expect_frames(1'b0, 7, DIV_A, 1'b1, "t4_frames", fs);
    repeat (200) @(negedge clk12);

    // 5: reset during bit 3 of the second byte of a 3-byte burst.
    push(1'b0, 8'h31, 1'b0, t[0], s);
    push(1'b0, 8'h32, 1'b0, t[1], s);
    push(1'b0, 8'h33, 1'b0, t[2], s);
    drop_valid(1'b0);
    target = t[0] + 1 + 10 * DIV_A + 4 * DIV_A + DIV_A / 2;
    while (cyc < target) @(negedge clk12);
    check("t5_line_low_before_rst", 32'(tx_a), 32'(8'h32 >> 3 & 1));
    rst_a = 1'b0;
    #1;
    check("t5_rst_tx", 32'(tx_a), 32'd1);
    check("t5_rst_ready", 32'(bus_a.data_ready), 32'd1);
    check("t5_rst_active", 32'(act_a), 32'd0);
    check("t5_rst_state", 32'(st_a), 32'd0);
    expect_frames(1'b0, 1, DIV_A, 1'b0, "t5_first", fs);
    exp_q_a.delete();
    repeat (2) @(negedge clk12);
    rst_a = 1'b1;
    low_cnt = 0; act_cnt = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk12);
      if (tx_a !== 1'b1) low_cnt++;
      if (act_a !== 1'b0) act_cnt++;
    end
    check("t5_quiet_line", 32'(low_cnt), 32'd0);
    check("t5_quiet_active", 32'(act_cnt), 32'd0);
    check("t5_no_frames", 32'(mon_q_a.size()), 32'd0);
    wave_check(1'b0, 8'h3C, DIV_A, "t5_after");
    expect_frames(1'b0, 1, DIV_A, 1'b0, "t5_after_byte", fs);

    // 6: DIV=4, depth 2.
    wave_check(1'b1, 8'h5A, DIV_B, "t6");
    expect_frames(1'b1, 1, DIV_B, 1'b0, "t6_byte", fs);
    repeat (20) @(negedge clk12);
    for (int i = 0; i < 4; i++) push(1'b1, 8'(8'hC0 + i), 1'b0, t[i], s);
    drop_valid(1'b1);
    check("t6_acc2", 32'(t[1] - t[0]), 32'd1);
    check("t6_acc3", 32'(t[2] - t[0]), 32'd2);
    check("t6_acc4", 32'(t[3] - t[0]), 32'd42);
    check("t6_ready_low_cycles", 32'(s), 32'd39);
    expect_frames(1'b1, 4, DIV_B, 1'b1, "t6_burst", fs);
    repeat (20) @(negedge clk12);
    for (int i = 0; i < 256; i++) begin
      push(1'b1, 8'($urandom_range(0, 255)), 1'b0, t[0], s);
      if ($urandom_range(0, 3) == 0) begin
        drop_valid(1'b1);
        repeat ($urandom_range(1, 60)) @(negedge clk12);
      end
    end
    drop_valid(1'b1);
    expect_frames(1'b1, 256, DIV_B, 1'b0, "t6_rand", fs);
    check("t6_sb_empty", 32'(exp_q_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
